// File: rtl/health_tracker_pkg.sv
// Shared fighter definitions: health width, damage width, default full health
// and the 2-bit fighter state encoding also decoded by the HUD.
package health_tracker_pkg;

  localparam int HEALTH_W            = 9;
  localparam int DAMAGE_W            = 8;
  localparam int FULL_HEALTH_DEFAULT = 200;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIVE  = 2'd1,
    ST_INVULN = 2'd2,
    ST_KO     = 2'd3
  } state_t;

endpackage

// File: rtl/health_tracker_damage_scaler.sv
// Converts a raw hit into effective damage, applying the blocking reduction
// while guaranteeing at least 1 point of chip damage for any non-zero hit.
module damage_scaler
  import health_tracker_pkg::*;
#(
  parameter int BLOCK_SHIFT = 2
) (
  input  logic [DAMAGE_W-1:0] hit_damage,
  input  logic                hit_blocked,
  output logic [DAMAGE_W-1:0] eff
);

  logic [DAMAGE_W-1:0] shifted;

  assign shifted = hit_damage >> BLOCK_SHIFT;

  always_comb begin
    eff = hit_damage;
    if (hit_blocked) begin
      eff = ((shifted == '0) && (hit_damage != '0)) ? DAMAGE_W'(1) : shifted;
    end
  end

endmodule

// File: rtl/health_tracker.sv
// One fighter's hit points: accepts hit requests, scales them for blocking,
// applies i-frames after damaging hits and reports KO to the HUD.
module health_tracker
  import health_tracker_pkg::*;
#(
  parameter int FULL_HEALTH  = FULL_HEALTH_DEFAULT,
  parameter int BLOCK_SHIFT  = 2,
  parameter int INVULN_TICKS = 30,
  parameter int CNT_W        = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                round_start,
  input  logic                tick,
  input  logic                hit_valid,
  input  logic [DAMAGE_W-1:0] hit_damage,
  input  logic                hit_blocked,
  output logic                hit_ready,
  output logic [HEALTH_W-1:0] curr_health,
  output logic                alive,
  output logic                invuln,
  output logic                ko_pulse,
  output logic [7:0]          hits_taken
);

  localparam logic [HEALTH_W-1:0] FULL_LOAD   = HEALTH_W'(FULL_HEALTH);
  localparam logic [CNT_W-1:0]    INVULN_LOAD = CNT_W'(INVULN_TICKS);

  state_t              state_reg, state_next;
  logic [HEALTH_W-1:0] health_reg, health_next;
  logic [7:0]          hits_reg, hits_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                ko_reg, ko_next;
  logic [DAMAGE_W-1:0] eff;
  logic [HEALTH_W-1:0] eff_ext;
  logic                accept;

  damage_scaler #(
    .BLOCK_SHIFT (BLOCK_SHIFT)
  ) u_scaler (
    .hit_damage  (hit_damage),
    .hit_blocked (hit_blocked),
    .eff         (eff)
  );

  assign eff_ext   = HEALTH_W'(eff);
  assign hit_ready = ((state_reg == ST_ALIVE) || (state_reg == ST_INVULN)) && !round_start;
  assign accept    = hit_valid && hit_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      health_reg <= '0;
      hits_reg   <= '0;
      cnt_reg    <= '0;
      ko_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      health_reg <= health_next;
      hits_reg   <= hits_next;
      cnt_reg    <= cnt_next;
      ko_reg     <= ko_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    health_next = health_reg;
    hits_next   = hits_reg;
    cnt_next    = cnt_reg;
    ko_next     = 1'b0;
    if (round_start) begin
      state_next  = ST_ALIVE;
      health_next = FULL_LOAD;
      hits_next   = '0;
      cnt_next    = '0;
    end else begin
      case (state_reg)
        ST_ALIVE: begin
          if (accept && (eff != '0)) begin
            hits_next = (hits_reg == 8'hFF) ? hits_reg : hits_reg + 8'd1;
            if (eff_ext >= health_reg) begin
              health_next = '0;
              state_next  = ST_KO;
              ko_next     = 1'b1;
            end else begin
              health_next = health_reg - eff_ext;
              if (INVULN_TICKS != 0) begin
                state_next = ST_INVULN;
                cnt_next   = INVULN_LOAD;
              end
            end
          end
        end
        // Hits accepted here are swallowed, including on the edge that ends i-frames.
        ST_INVULN: begin
          if (tick) begin
            if (cnt_reg <= CNT_W'(1)) begin
              cnt_next   = '0;
              state_next = ST_ALIVE;
            end else begin
              cnt_next = cnt_reg - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign curr_health = health_reg;
  assign hits_taken  = hits_reg;
  assign ko_pulse    = ko_reg;
  assign alive       = (state_reg == ST_ALIVE) || (state_reg == ST_INVULN);
  assign invuln      = (state_reg == ST_INVULN);

endmodule

// File: tb/tb_health_tracker.sv
// Self-checking bench: vector table through a scoreboard queue for the default
// tracker, plus hand sequences for reset and hit-counter saturation.
module tb_health_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       round_start, tick, hit_valid, hit_blocked;
  logic [7:0] hit_damage;
  logic       hit_ready, alive, invuln, ko_pulse;
  logic [8:0] curr_health;
  logic [7:0] hits_taken;

  logic       round_start2, tick2, hit_valid2, hit_blocked2;
  logic [7:0] hit_damage2;
  logic       hit_ready2, alive2, invuln2, ko_pulse2;
  logic [8:0] curr_health2;
  logic [7:0] hits_taken2;

  always #5 clk = ~clk;

  health_tracker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .round_start (round_start),
    .tick        (tick),
    .hit_valid   (hit_valid),
    .hit_damage  (hit_damage),
    .hit_blocked (hit_blocked),
    .hit_ready   (hit_ready),
    .curr_health (curr_health),
    .alive       (alive),
    .invuln      (invuln),
    .ko_pulse    (ko_pulse),
    .hits_taken  (hits_taken)
  );

  health_tracker #(
    .FULL_HEALTH  (511),
    .INVULN_TICKS (0)
  ) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .round_start (round_start2),
    .tick        (tick2),
    .hit_valid   (hit_valid2),
    .hit_damage  (hit_damage2),
    .hit_blocked (hit_blocked2),
    .hit_ready   (hit_ready2),
    .curr_health (curr_health2),
    .alive       (alive2),
    .invuln      (invuln2),
    .ko_pulse    (ko_pulse2),
    .hits_taken  (hits_taken2)
  );

  typedef struct {
    logic       rs, tk, hv;
    logic [7:0] dmg;
    logic       blk;
    int         reps;
    logic       rdy;
    logic [8:0] hp;
    logic       al, iv, ko;
    logic [7:0] hits;
  } vec_t;

  typedef struct {
    logic [8:0] hp;
    logic       al, iv, ko;
    logic [7:0] hits;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[20];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic rs, logic tk, logic hv, logic [7:0] dmg, logic blk,
                              int reps, logic rdy, logic [8:0] hp, logic al, logic iv,
                              logic ko, logic [7:0] hits);
    vec_t v;
    v.rs = rs; v.tk = tk; v.hv = hv; v.dmg = dmg; v.blk = blk; v.reps = reps;
    v.rdy = rdy; v.hp = hp; v.al = al; v.iv = iv; v.ko = ko; v.hits = hits;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic cmp_pop(input string tag, input logic [8:0] hp, input logic al,
                         input logic iv, input logic ko, input logic [7:0] hits);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " curr_health"}, 32'(hp), 32'(e.hp));
      chk({tag, " alive"}, 32'(al), 32'(e.al));
      chk({tag, " invuln"}, 32'(iv), 32'(e.iv));
      chk({tag, " ko_pulse"}, 32'(ko), 32'(e.ko));
      chk({tag, " hits_taken"}, 32'(hits), 32'(e.hits));
    end
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    exp_t e;
    for (int r = 0; r < t.reps; r++) begin
      round_start = t.rs; tick = t.tk; hit_valid = t.hv;
      hit_damage = t.dmg; hit_blocked = t.blk;
      #1;
      if (r == 0) chk($sformatf("v%0d hit_ready", idx), 32'(hit_ready), 32'(t.rdy));
      if (r == t.reps - 1) begin
        e.hp = t.hp; e.al = t.al; e.iv = t.iv; e.ko = t.ko; e.hits = t.hits;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    round_start = 1'b0; tick = 1'b0; hit_valid = 1'b0;
    cmp_pop($sformatf("v%0d", idx), curr_health, alive, invuln, ko_pulse, hits_taken);
    $display("vec %0d: rs=%0d tick=%0d valid=%0d dmg=%0d blk=%0d x%0d -> health=%0d alive=%0d invuln=%0d ko=%0d hits=%0d",
             idx, t.rs, t.tk, t.hv, t.dmg, t.blk, t.reps, curr_health, alive, invuln,
             ko_pulse, hits_taken);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e2;
    //                rs tk hv dmg  blk reps rdy hp   al iv ko hits
    vecs[0]  = mk(1, 0, 0, 8'd0,   0, 1,  0, 9'd200, 1, 0, 0, 8'd0);
    vecs[1]  = mk(0, 0, 1, 8'd50,  0, 1,  1, 9'd150, 1, 1, 0, 8'd1);
    vecs[2]  = mk(0, 0, 1, 8'd100, 0, 1,  1, 9'd150, 1, 1, 0, 8'd1);
    vecs[3]  = mk(0, 1, 0, 8'd0,   0, 29, 1, 9'd150, 1, 1, 0, 8'd1);
    vecs[4]  = mk(0, 1, 1, 8'd100, 0, 1,  1, 9'd150, 1, 0, 0, 8'd1);
    vecs[5]  = mk(0, 0, 1, 8'd40,  1, 1,  1, 9'd140, 1, 1, 0, 8'd2);
    vecs[6]  = mk(0, 1, 0, 8'd0,   0, 30, 1, 9'd140, 1, 0, 0, 8'd2);
    vecs[7]  = mk(0, 0, 1, 8'd3,   1, 1,  1, 9'd139, 1, 1, 0, 8'd3);
    vecs[8]  = mk(0, 1, 0, 8'd0,   0, 30, 1, 9'd139, 1, 0, 0, 8'd3);
    vecs[9]  = mk(0, 0, 1, 8'd0,   1, 1,  1, 9'd139, 1, 0, 0, 8'd3);
    vecs[10] = mk(0, 0, 1, 8'd0,   0, 1,  1, 9'd139, 1, 0, 0, 8'd3);
    vecs[11] = mk(0, 0, 1, 8'd119, 0, 1,  1, 9'd20,  1, 1, 0, 8'd4);
    vecs[12] = mk(0, 1, 0, 8'd0,   0, 30, 1, 9'd20,  1, 0, 0, 8'd4);
    vecs[13] = mk(0, 0, 1, 8'd255, 0, 1,  1, 9'd0,   0, 0, 1, 8'd5);
    vecs[14] = mk(0, 1, 1, 8'd50,  0, 1,  0, 9'd0,   0, 0, 0, 8'd5);
    vecs[15] = mk(0, 1, 1, 8'd50,  0, 3,  0, 9'd0,   0, 0, 0, 8'd5);
    vecs[16] = mk(1, 0, 1, 8'd50,  0, 1,  0, 9'd200, 1, 0, 0, 8'd0);
    vecs[17] = mk(0, 0, 1, 8'd50,  0, 1,  1, 9'd150, 1, 1, 0, 8'd1);
    vecs[18] = mk(1, 0, 1, 8'd50,  0, 1,  0, 9'd200, 1, 0, 0, 8'd0);
    vecs[19] = mk(0, 0, 1, 8'd50,  0, 1,  1, 9'd150, 1, 1, 0, 8'd1);

    round_start = 0; tick = 0; hit_valid = 0; hit_damage = 0; hit_blocked = 0;
    round_start2 = 0; tick2 = 0; hit_valid2 = 0; hit_damage2 = 0; hit_blocked2 = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset curr_health", 32'(curr_health), 32'd0);
    chk("reset alive", 32'(alive), 32'd0);
    chk("reset invuln", 32'(invuln), 32'd0);
    chk("reset hit_ready", 32'(hit_ready), 32'd0);
    chk("reset ko_pulse", 32'(ko_pulse), 32'd0);
    chk("reset hits_taken", 32'(hits_taken), 32'd0);
    rst_n = 1'b1;
    hit_valid = 1'b1; hit_damage = 8'd10; tick = 1'b1;
    @(posedge clk); #1;
    chk("idle hit_ready", 32'(hit_ready), 32'd0);
    chk("idle curr_health", 32'(curr_health), 32'd0);
    hit_valid = 1'b0; tick = 1'b0;
    $display("reset: health=%0d alive=%0d ready=%0d", curr_health, alive, hit_ready);

    for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

    // async reset while in i-frames with a hit pending
    hit_valid = 1'b1; hit_damage = 8'd50;
    #3 rst_n = 1'b0;
    #1;
    chk("midreset curr_health", 32'(curr_health), 32'd0);
    chk("midreset alive", 32'(alive), 32'd0);
    chk("midreset invuln", 32'(invuln), 32'd0);
    chk("midreset hit_ready", 32'(hit_ready), 32'd0);
    chk("midreset hits_taken", 32'(hits_taken), 32'd0);
    $display("midreset: health=%0d alive=%0d invuln=%0d", curr_health, alive, invuln);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postreset curr_health", 32'(curr_health), 32'd0);
    chk("postreset hits_taken", 32'(hits_taken), 32'd0);
    hit_valid = 1'b0;

    // hits_taken saturation on a tracker without i-frames
    round_start2 = 1'b1;
    @(posedge clk); #1;
    round_start2 = 1'b0;
    chk("sat start curr_health", 32'(curr_health2), 32'd511);
    for (int i = 1; i <= 300; i++) begin
      hit_valid2 = 1'b1; hit_damage2 = 8'd1; hit_blocked2 = (i % 2 == 0);
      #1;
      if (i == 1) chk("sat hit_ready", 32'(hit_ready2), 32'd1);
      e2.hp = 9'(511 - i); e2.al = 1'b1; e2.iv = 1'b0; e2.ko = 1'b0;
      e2.hits = (i > 255) ? 8'd255 : 8'(i);
      exp_q.push_back(e2);
      @(posedge clk); #1;
      cmp_pop($sformatf("sat%0d", i), curr_health2, alive2, invuln2, ko_pulse2, hits_taken2);
    end
    hit_valid2 = 1'b0;
    $display("saturation: health=%0d hits=%0d", curr_health2, hits_taken2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
